// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage: widths, reset PC,
// fetch FSM encoding and the queue entry layout.
package fetch_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 48;
    localparam int INSTR_W = 24;
    localparam int DEF_DEPTH = 4;
    localparam logic [ADDR_W-1:0] DEF_RESET_PC = 12'h800;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } qentry_t;

    // First PC of the memory word after the one holding pc.
    function automatic logic [ADDR_W-1:0] next_word_pc(input logic [ADDR_W-1:0] pc);
        return (pc | {{(ADDR_W-1){1'b0}}, 1'b1}) + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit_instr_queue.sv
// Instruction FIFO kept as a shift register with entry 0 at the head; accepts
// up to two pushes and one pop per cycle and presents a registered head.
module instr_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [1:0]    push_cnt,
    input  qentry_t       push0,
    input  qentry_t       push1,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output qentry_t       head
);

    qentry_t       ent_r [DEPTH];
    qentry_t       ent_s [DEPTH];
    qentry_t       sh_s  [DEPTH];
    qentry_t       head_r;
    logic          valid_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] base_s;
    logic [CW:0]   sum_s;

    // Next queue contents: optional pop (shift down), then pushes appended at the tail.
    always_comb begin
        sh_s   = ent_r;
        base_s = cnt_r;
        if (!flush && pop && (cnt_r != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                sh_s[i] = ent_r[i + 1];
            end
            base_s = cnt_r - CW'(1);
        end else begin
            base_s = cnt_r;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush && (push_cnt != 2'd0) && (i == int'(base_s))) begin
                ent_s[i] = push0;
            end else if (!flush && (push_cnt == 2'd2) && (i == int'(base_s) + 1)) begin
                ent_s[i] = push1;
            end else begin
                ent_s[i] = sh_s[i];
            end
        end
        sum_s = {1'b0, base_s} + {{(CW - 1){1'b0}}, push_cnt};
        if (flush) begin
            cnt_s = '0;
        end else if (sum_s > (CW + 1)'(DEPTH)) begin
            cnt_s = CW'(DEPTH);
        end else begin
            cnt_s = sum_s[CW-1:0];
        end
    end

    // Storage, occupancy and head register; the head keeps its last value when empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
            cnt_r   <= '0;
            valid_r <= 1'b0;
            head_r  <= '0;
        end else begin
            ent_r   <= ent_s;
            cnt_r   <= cnt_s;
            valid_r <= (cnt_s != '0);
            if (cnt_s != '0) begin
                head_r <= ent_s[0];
            end else begin
                head_r <= head_r;
            end
        end
    end

    assign count      = cnt_r;
    assign head_valid = valid_r;
    assign head       = head_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests 48-bit words from memory, splits
// them into two instructions and queues them for the core; redirects flush and restart.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int                DEPTH    = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_adr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  memdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      state_r;
    fetch_state_e      state_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] fetch_pc_s;
    logic [ADDR_W-1:0] pend_pc_r;
    logic [ADDR_W-1:0] pend_pc_s;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_adr_r;
    logic              flush_s;
    logic              pop_s;
    logic [1:0]        push_cnt_s;
    qentry_t           push0_s;
    qentry_t           push1_s;
    qentry_t           even_s;
    qentry_t           odd_s;
    qentry_t           head_s;
    logic              head_valid_s;
    logic [CW-1:0]     count_s;
    logic [CW:0]       post_s;

    // Fetch FSM next state, PC update and queue push/pop/flush control.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        pend_pc_s  = pend_pc_r;
        flush_s    = 1'b0;
        push_cnt_s = 2'd0;
        push0_s    = '0;
        push1_s    = '0;
        even_s     = '{instr: memdata[DATA_W-1:INSTR_W], pc: fetch_pc_r};
        odd_s      = '{instr: memdata[INSTR_W-1:0], pc: fetch_pc_r | {{(ADDR_W-1){1'b0}}, 1'b1}};
        pop_s      = head_valid_s && instr_ready && !redirect;
        post_s     = {1'b0, count_s};
        if (redirect) begin
            // Redirect wins over everything; an unanswered request must be drained first.
            flush_s    = 1'b1;
            fetch_pc_s = redirect_pc;
            pend_pc_s  = redirect_pc;
            case (state_r)
                HOLD:    state_s = FETCH;
                FETCH:   state_s = mem_ack ? FETCH : DRAIN;
                DRAIN:   state_s = mem_ack ? FETCH : DRAIN;
                default: state_s = HOLD;
            endcase
        end else begin
            case (state_r)
                HOLD: begin
                    state_s = (count_s <= CW'(DEPTH - 2)) ? FETCH : HOLD;
                end
                FETCH: begin
                    if (mem_ack) begin
                        if (fetch_pc_r[0]) begin
                            push_cnt_s = 2'd1;
                            push0_s    = odd_s;
                        end else begin
                            push_cnt_s = 2'd2;
                            push0_s    = even_s;
                            push1_s    = odd_s;
                        end
                        fetch_pc_s = next_word_pc(fetch_pc_r);
                        post_s     = {1'b0, count_s} - {{CW{1'b0}}, pop_s}
                                     + {{(CW - 1){1'b0}}, push_cnt_s};
                        state_s    = (post_s <= (CW + 1)'(DEPTH - 2)) ? FETCH : HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        fetch_pc_s = pend_pc_r;
                        state_s    = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: state_s = HOLD;
            endcase
        end
    end

    // State, PC and memory request registers; mem_adr is frozen while draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= HOLD;
            fetch_pc_r <= RESET_PC;
            pend_pc_r  <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_adr_r  <= RESET_PC >> 1;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            pend_pc_r  <= pend_pc_s;
            mem_req_r  <= (state_s != HOLD);
            if (state_s == DRAIN) begin
                mem_adr_r <= mem_adr_r;
            end else begin
                mem_adr_r <= fetch_pc_s >> 1;
            end
        end
    end

    instr_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_s),
        .push_cnt   (push_cnt_s),
        .push0      (push0_s),
        .push1      (push1_s),
        .pop        (pop_s),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

    assign mem_req     = mem_req_r;
    assign mem_adr     = mem_adr_r;
    assign instr_valid = head_valid_s;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a transaction-level queue model of the fetch stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [11:0] mem_adr;
    logic        mem_ack;
    logic [47:0] memdata;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic [23:0] instr;
    logic [11:0] instr_pc;
    logic        instr_ready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [23:0] instr;
        logic [11:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [11:0] m_fpc;
    logic [11:0] e_adr;
    logic        e_req;
    logic        m_drain;
    logic [23:0] m_out_instr;
    logic [11:0] m_out_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (rst_n),
        .mem_req     (mem_req),
        .mem_adr     (mem_adr),
        .mem_ack     (mem_ack),
        .memdata     (memdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    function automatic logic [47:0] word_of(input logic [11:0] adr);
        return {12'h5A5, adr, 12'hC3C, adr};
    endfunction

    function automatic logic [23:0] instr_of(input logic [11:0] pc);
        logic [11:0] a;
        a = pc >> 1;
        return pc[0] ? {12'hC3C, a} : {12'h5A5, a};
    endfunction

    // One clock: the model consumes the inputs seen at the edge, outputs sampled 1 ns later.
    task automatic tick();
        logic pre_req;
        logic pre_valid;
        ent_t e;
        pre_req   = mem_req;
        pre_valid = instr_valid;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_fpc = 12'h800; m_drain = 1'b0; e_req = 1'b0; e_adr = 12'h400;
            m_out_instr = 24'h0; m_out_pc = 12'h0;
        end else if (redirect) begin
            mq.delete();
            m_drain = pre_req && !mem_ack;
            if (!m_drain) e_adr = redirect_pc >> 1;
            m_fpc = redirect_pc;
            e_req = 1'b1;
        end else begin
            if (pre_valid && instr_ready) void'(mq.pop_front());
            if (pre_req && mem_ack) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                end else begin
                    if (!m_fpc[0]) begin
                        e.instr = memdata[47:24]; e.pc = m_fpc; mq.push_back(e);
                    end
                    e.instr = memdata[23:0]; e.pc = m_fpc | 12'h001; mq.push_back(e);
                    m_fpc = (m_fpc | 12'h001) + 12'h001;
                end
                e_req = (mq.size() <= 2);
                e_adr = m_fpc >> 1;
            end else if (!pre_req) begin
                e_req = (mq.size() + ((pre_valid && instr_ready) ? 1 : 0) <= 2);
                e_adr = m_fpc >> 1;
            end
        end
        if (mq.size() != 0) begin
            m_out_instr = mq[0].instr;
            m_out_pc    = mq[0].pc;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ack = 1'b0; memdata = 48'h0; redirect = 1'b0;
        redirect_pc = 12'h0; instr_ready = 1'b0;
        tick(); tick();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
        tests++; if (mem_adr !== 12'h400) begin fails++; $display("FAIL reset_adr: got %h want 400", mem_adr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        tests++; if (instr !== 24'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
        tests++; if (instr_pc !== 12'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    endtask

    task automatic test_basic();
        rst_n = 1'b1; instr_ready = 1'b1;
        tick();
        tests++; if (mem_req !== 1'b1 || mem_adr !== 12'h400) begin fails++; $display("FAIL basic_req: got %b/%h want 1/400", mem_req, mem_adr); end
        mem_ack = 1'b1; memdata = {24'hAAAAAA, 24'hBBBBBB};
        tick(); mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== 24'hAAAAAA || instr_pc !== 12'h800) begin fails++; $display("FAIL basic_first: got %b %h@%h want 1 aaaaaa@800", instr_valid, instr, instr_pc); end
        tests++; if (mem_req !== 1'b1 || mem_adr !== 12'h401) begin fails++; $display("FAIL basic_next_adr: got %b/%h want 1/401", mem_req, mem_adr); end
        tick();
        tests++; if (instr_valid !== 1'b1 || instr !== 24'hBBBBBB || instr_pc !== 12'h801) begin fails++; $display("FAIL basic_second: got %b %h@%h want 1 bbbbbb@801", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_fill();
        rst_n = 1'b0; mem_ack = 1'b0; tick();
        rst_n = 1'b1; instr_ready = 1'b0; tick();
        mem_ack = 1'b1; memdata = word_of(mem_adr); tick();
        memdata = word_of(mem_adr); tick();
        mem_ack = 1'b0;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL fill_stop: got mem_req %b want 0", mem_req); end
        tick(); tick();
        tests++; if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 12'h800) begin fails++; $display("FAIL fill_hold: got %b %b %h want 0 1 800", mem_req, instr_valid, instr_pc); end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== 12'h800 + 12'(i) || instr !== instr_of(12'h800 + 12'(i))) begin
                fails++; $display("FAIL fill_drain%0d: got %b %h@%h want 1 %h@%h", i, instr_valid, instr, instr_pc, instr_of(12'h800 + 12'(i)), 12'h800 + 12'(i));
            end
            tick();
        end
        tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_adr !== 12'h402) begin fails++; $display("FAIL fill_resume: got %b %b %h want 0 1 402", instr_valid, mem_req, mem_adr); end
    endtask

    task automatic test_redirect_hold();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 12'h123; tick();
        redirect = 1'b0;
        tests++; if (mem_req !== 1'b1 || mem_adr !== 12'h091) begin fails++; $display("FAIL rhold_req: got %b/%h want 1/091", mem_req, mem_adr); end
        mem_ack = 1'b1; memdata = {24'h111111, 24'h222222}; instr_ready = 1'b1; tick();
        mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr !== 24'h222222 || instr_pc !== 12'h123) begin fails++; $display("FAIL rhold_odd: got %b %h@%h want 1 222222@123", instr_valid, instr, instr_pc); end
        tests++; if (mem_adr !== 12'h092) begin fails++; $display("FAIL rhold_adr: got %h want 092", mem_adr); end
        tick();
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rhold_single: got valid %b want 0", instr_valid); end
    endtask

    task automatic test_redirect_wait();
        redirect = 1'b1; redirect_pc = 12'h040; tick();
        redirect = 1'b0;
        tests++; if (mem_req !== 1'b1 || mem_adr !== 12'h092) begin fails++; $display("FAIL rwait_hold: got %b/%h want 1/092", mem_req, mem_adr); end
        tick(); tick();
        tests++; if (mem_adr !== 12'h092 || instr_valid !== 1'b0) begin fails++; $display("FAIL rwait_stable: got %h %b want 092 0", mem_adr, instr_valid); end
        mem_ack = 1'b1; memdata = {24'h0DEAD0, 24'h0BEEF0}; tick();
        mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_adr !== 12'h020) begin fails++; $display("FAIL rwait_discard: got %b %b %h want 0 1 020", instr_valid, mem_req, mem_adr); end
        mem_ack = 1'b1; memdata = word_of(12'h020); tick();
        mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'h040 || instr !== instr_of(12'h040)) begin fails++; $display("FAIL rwait_new: got %b %h@%h want 1 %h@040", instr_valid, instr, instr_pc, instr_of(12'h040)); end
    endtask

    task automatic test_same_cycle();
        redirect = 1'b1; redirect_pc = 12'h200; mem_ack = 1'b1; memdata = word_of(12'h021); instr_ready = 1'b1;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_adr !== 12'h100) begin fails++; $display("FAIL same_ack_pop: got %b %b %h want 0 1 100", instr_valid, mem_req, mem_adr); end
        mem_ack = 1'b1; memdata = word_of(12'h100); tick();
        mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'h200) begin fails++; $display("FAIL same_restart: got %b %h want 1 200", instr_valid, instr_pc); end
        redirect = 1'b1; redirect_pc = 12'h300; tick();
        redirect = 1'b0;
        tests++; if (instr_valid !== 1'b0 || mem_adr !== 12'h101) begin fails++; $display("FAIL same_pop_flush: got %b %h want 0 101", instr_valid, mem_adr); end
        mem_ack = 1'b1; memdata = word_of(12'h101); tick();
        mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b0 || mem_adr !== 12'h180) begin fails++; $display("FAIL same_drain: got %b %h want 0 180", instr_valid, mem_adr); end
    endtask

    task automatic test_wrap_reset();
        redirect = 1'b1; redirect_pc = 12'hFFE; mem_ack = 1'b1; memdata = word_of(12'h180); tick();
        redirect = 1'b0; mem_ack = 1'b0;
        tests++; if (mem_adr !== 12'h7FF) begin fails++; $display("FAIL wrap_adr7ff: got %h want 7ff", mem_adr); end
        mem_ack = 1'b1; memdata = word_of(12'h7FF); tick();
        mem_ack = 1'b0;
        tests++; if (instr_pc !== 12'hFFE || mem_adr !== 12'h000) begin fails++; $display("FAIL wrap_ffe: got %h adr %h want ffe adr 000", instr_pc, mem_adr); end
        tick();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 12'hFFF) begin fails++; $display("FAIL wrap_fff: got %b %h want 1 fff", instr_valid, instr_pc); end
        mem_ack = 1'b1; memdata = word_of(12'h000); tick();
        mem_ack = 1'b0;
        tests++; if (instr_pc !== 12'h000 || instr !== instr_of(12'h000)) begin fails++; $display("FAIL wrap_000: got %h@%h want %h@000", instr, instr_pc, instr_of(12'h000)); end
        rst_n = 1'b0; tick();
        tests++; if (mem_req !== 1'b0 || mem_adr !== 12'h400 || instr_valid !== 1'b0 || instr !== 24'h0 || instr_pc !== 12'h0) begin
            fails++; $display("FAIL wrap_reset: got %b %h %b %h %h want 0 400 0 0 0", mem_req, mem_adr, instr_valid, instr, instr_pc);
        end
        rst_n = 1'b1; mem_ack = 1'b1; memdata = word_of(12'h001); tick();
        mem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_adr !== 12'h400) begin fails++; $display("FAIL late_ack: got %b %b %h want 0 1 400", instr_valid, mem_req, mem_adr); end
        tick();
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL late_ack_quiet: got valid %b want 0", instr_valid); end
    endtask

    task automatic test_random();
        logic [63:0] r;
        rst_n = 1'b0; redirect = 1'b0; mem_ack = 1'b0; tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            r = {$urandom, $urandom};
            rst_n       = ($urandom_range(0, 599) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = r[59:48];
            mem_ack     = ($urandom_range(0, 2) == 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            memdata     = r[47:0];
            tick();
            tests++; if (mem_req !== e_req) begin fails++; $display("FAIL rnd_req c%0d: got %b want %b", c, mem_req, e_req); end
            if (e_req) begin
                tests++; if (mem_adr !== e_adr) begin fails++; $display("FAIL rnd_adr c%0d: got %h want %h", c, mem_adr, e_adr); end
            end
            tests++; if (instr_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instr_valid, mq.size() != 0); end
            tests++; if (instr !== m_out_instr) begin fails++; $display("FAIL rnd_instr c%0d: got %h want %h", c, instr, m_out_instr); end
            tests++; if (instr_pc !== m_out_pc) begin fails++; $display("FAIL rnd_pc c%0d: got %h want %h", c, instr_pc, m_out_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_redirect_hold();
        test_redirect_wait();
        test_same_cycle();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
